// File: rtl/dmem_mmio_unit.sv
// Data-memory stage consumer: word RAM plus memory-mapped LEDs, switches,
// cycle counter and an 8N1 UART transmitter. Load data is combinational so
// the core's MEM/WB register captures it in the same cycle as the request.
module dmem_mmio_unit #(
  parameter int          RAM_WORDS    = 256,
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [15:0] IO_BASE      = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  output logic [7:0]  leds,
  input  logic [3:0]  switches,
  output logic        uart_tx,
  output logic        bus_err
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [16:0] RAM_BYTES = 17'(2 * RAM_WORDS);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BIT - 1);

  // Register offsets from IO_BASE (byte addresses, always even)
  localparam logic [15:0] OFF_LED  = 16'h0000;
  localparam logic [15:0] OFF_SW   = 16'h0002;
  localparam logic [15:0] OFF_UDAT = 16'h0004;
  localparam logic [15:0] OFF_USTA = 16'h0006;
  localparam logic [15:0] OFF_CYC  = 16'h0008;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Address decode; a[0] is ignored for every target
  logic          is_ram, is_io, is_hole;
  logic [AW-1:0] ram_idx;
  logic [15:0]   io_off;
  logic          wr_led, wr_udat, wr_usta, wr_cyc;

  assign is_ram  = ({1'b0, dmemaddr} < RAM_BYTES);
  assign is_io   = (dmemaddr >= IO_BASE);
  assign is_hole = !is_ram && !is_io;
  assign ram_idx = dmemaddr[AW:1];
  assign io_off  = {dmemaddr[15:1], 1'b0} - IO_BASE;

  assign wr_led  = dmemwrite && is_io && (io_off == OFF_LED);
  assign wr_udat = dmemwrite && is_io && (io_off == OFF_UDAT);
  assign wr_usta = dmemwrite && is_io && (io_off == OFF_USTA);
  assign wr_cyc  = dmemwrite && is_io && (io_off == OFF_CYC);

  // Data RAM: contents survive reset, read is asynchronous
  logic [15:0] ram [RAM_WORDS];

  // RAM store port, committed on the clock edge
  always_ff @(posedge clock) begin
    if (dmemwrite && is_ram) ram[ram_idx] <= dmemwdata;
  end

  // State registers
  logic [7:0]  leds_q, leds_d;
  logic [15:0] cycle_q, cycle_d;
  logic        overrun_q, overrun_d;
  logic        bus_err_q, bus_err_d;
  logic [3:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  uart_state_t state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy;

  assign busy = (state_q != IDLE);

  // Load data mux: zero when no load, hole, or unmapped IO offset
  always_comb begin
    dmemrdata = 16'h0000;
    if (dmemread) begin
      if (is_ram) begin
        dmemrdata = ram[ram_idx];
      end else if (is_io) begin
        case (io_off)
          OFF_LED:  dmemrdata = {8'h00, leds_q};
          OFF_SW:   dmemrdata = {12'h000, sw_sync_q};
          OFF_USTA: dmemrdata = {14'h0000, overrun_q, busy};
          OFF_CYC:  dmemrdata = cycle_q;
          default:  dmemrdata = 16'h0000;
        endcase
      end
    end
  end

  // Next state for LEDs, cycle counter, overrun, sticky error and synchroniser
  always_comb begin
    leds_d    = wr_led ? dmemwdata[7:0] : leds_q;
    cycle_d   = wr_cyc ? dmemwdata : cycle_q + 16'd1;
    overrun_d = overrun_q;
    if (wr_usta) overrun_d = 1'b0;
    if (wr_udat && busy) overrun_d = 1'b1;   // set beats clear
    bus_err_d = bus_err_q | ((dmemread | dmemwrite) & (dmemaddr[0] | is_hole));
    sw_meta_d = switches;
    sw_sync_d = sw_meta_q;
  end

  // UART transmitter: each state holds for CLKS_PER_BIT clocks; tx is registered
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (wr_udat) begin
          state_d = START;
          baud_d  = BAUD_LOAD;
          shift_d = dmemwdata[7:0];
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          baud_d  = BAUD_LOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) state_d = IDLE;
        else              baud_d  = baud_q - CW'(1);
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Register update with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      leds_q    <= 8'h00;
      cycle_q   <= 16'h0000;
      overrun_q <= 1'b0;
      bus_err_q <= 1'b0;
      sw_meta_q <= 4'h0;
      sw_sync_q <= 4'h0;
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      leds_q    <= leds_d;
      cycle_q   <= cycle_d;
      overrun_q <= overrun_d;
      bus_err_q <= bus_err_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign leds    = leds_q;
  assign uart_tx = tx_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Self-checking bench for dmem_mmio_unit: randomized bus traffic checked
// against a word-level memory model and frame-level UART expectations.
module tb_dmem_mmio_unit;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dmemaddr = 16'h0;
  logic [15:0] dmemwdata = 16'h0;
  logic        dmemwrite = 1'b0;
  logic        dmemread = 1'b0;
  logic [15:0] dmemrdata;
  logic [7:0]  leds;
  logic [3:0]  switches = 4'h0;
  logic        uart_tx;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  // Reference RAM: word index -> last stored value
  logic [15:0] ref_mem [int];

  dmem_mmio_unit #(
    .RAM_WORDS(256),
    .CLKS_PER_BIT(CPB),
    .IO_BASE(16'hFF00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dmemaddr(dmemaddr),
    .dmemwdata(dmemwdata),
    .dmemwrite(dmemwrite),
    .dmemread(dmemread),
    .dmemrdata(dmemrdata),
    .leds(leds),
    .switches(switches),
    .uart_tx(uart_tx),
    .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one bus request and let combinational read data settle
  task automatic bus(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd);
    dmemread  = rd;
    dmemwrite = wr;
    dmemaddr  = a;
    dmemwdata = wd;
    if (wr) $display("  store %h <- %h", a, wd);
    #1;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    switches = 4'hF;
    idle();
    tick();
    tick();
    reset = 1'b0;
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h want 00", leds); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    bus(1'b1, 1'b0, 16'hFF08, 16'h0);
    checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL reset_cycle: got %h want 0000", dmemrdata); end
    bus(1'b1, 1'b0, 16'hFF06, 16'h0);
    checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL reset_uartsta: got %h want 0000", dmemrdata); end
    bus(1'b1, 1'b0, 16'hFF02, 16'h0);
    checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL reset_sw_sync: got %h want 0000", dmemrdata); end
    tick();
    bus(1'b1, 1'b0, 16'hFF08, 16'h0);
    checks++; if (dmemrdata !== 16'h0001) begin errors++; $display("FAIL reset_cycle_inc: got %h want 0001", dmemrdata); end
    idle();
    $display("test_reset done");
  endtask

  task automatic test_ram();
    logic [15:0] d, old_v, new_v;
    int idx;
    bus(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL ram_noread_zero: got %h want 0000", dmemrdata); end
    tick();
    ref_mem[8] = 16'hBEEF;
    bus(1'b1, 1'b0, 16'h0010, 16'h0);
    checks++; if (dmemrdata !== 16'hBEEF) begin errors++; $display("FAIL ram_beef: got %h want BEEF", dmemrdata); end
    for (int n = 0; n < 16; n++) begin
      idx = $urandom_range(0, 255);
      if (idx == 8) idx = 9;
      d = 16'($urandom);
      bus(1'b0, 1'b1, 16'(idx * 2), d);
      tick();
      ref_mem[idx] = d;
    end
    d = 16'($urandom);
    bus(1'b0, 1'b1, 16'h01FE, d);
    tick();
    ref_mem[255] = d;
    foreach (ref_mem[k]) begin
      bus(1'b1, 1'b0, 16'(k * 2), 16'h0);
      checks++; if (dmemrdata !== ref_mem[k]) begin errors++; $display("FAIL ram_read a=%h: got %h want %h", 16'(k * 2), dmemrdata, ref_mem[k]); end
    end
    // read-during-write returns the value held before the edge
    old_v = 16'($urandom);
    new_v = ~old_v;
    bus(1'b0, 1'b1, 16'h0012, old_v);
    tick();
    ref_mem[9] = old_v;
    bus(1'b1, 1'b1, 16'h0012, new_v);
    checks++; if (dmemrdata !== old_v) begin errors++; $display("FAIL ram_rw_same: got %h want %h", dmemrdata, old_v); end
    tick();
    ref_mem[9] = new_v;
    bus(1'b1, 1'b0, 16'h0012, 16'h0);
    checks++; if (dmemrdata !== new_v) begin errors++; $display("FAIL ram_rw_after: got %h want %h", dmemrdata, new_v); end
    idle();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL ram_no_err: got %b want 0", bus_err); end
    $display("test_ram done");
  endtask

  task automatic test_leds_switches();
    logic [15:0] w;
    logic [3:0]  cur, nv;
    bus(1'b0, 1'b1, 16'hFF00, 16'h00A5);
    tick();
    idle();
    checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL leds_a5: got %h want A5", leds); end
    for (int n = 0; n < 4; n++) begin
      w = 16'($urandom);
      bus(1'b0, 1'b1, 16'hFF00, w);
      tick();
      bus(1'b1, 1'b0, 16'hFF00, 16'h0);
      checks++; if (leds !== w[7:0]) begin errors++; $display("FAIL leds_rand: got %h want %h", leds, w[7:0]); end
      checks++; if (dmemrdata !== {8'h00, w[7:0]}) begin errors++; $display("FAIL leds_read: got %h want %h", dmemrdata, {8'h00, w[7:0]}); end
    end
    cur = switches;
    for (int n = 0; n < 4; n++) begin
      nv = (n == 0) ? 4'b1010 : 4'($urandom_range(0, 15));
      if (nv == cur) nv = ~cur;
      switches = nv;
      for (int c = 1; c <= 3; c++) begin
        bus(1'b1, 1'b0, 16'hFF02, 16'h0);
        checks++;
        if (dmemrdata !== {12'h000, (c >= 3) ? nv : cur}) begin
          errors++; $display("FAIL sw_sync cycle%0d: got %h want %h", c, dmemrdata, {12'h000, (c >= 3) ? nv : cur});
        end
        tick();
      end
      cur = nv;
    end
    idle();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL pre_hole_err: got %b want 0", bus_err); end
    bus(1'b1, 1'b0, 16'h0201, 16'h0);
    checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL hole_read: got %h want 0000", dmemrdata); end
    tick();
    idle();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL hole_err: got %b want 1", bus_err); end
    $display("test_leds_switches done");
  endtask

  task automatic test_odd_hole();
    logic [15:0] v;
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", bus_err); end
    // unmapped IO offsets and the last RAM word raise no error
    bus(1'b1, 1'b0, 16'hFF0A, 16'h0);
    checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL io_unmapped_rd: got %h want 0000", dmemrdata); end
    tick();
    bus(1'b0, 1'b1, 16'hFF0E, 16'h1234);
    tick();
    bus(1'b1, 1'b0, 16'h01FE, 16'h0);
    checks++; if (dmemrdata !== ref_mem[255]) begin errors++; $display("FAIL ram_last: got %h want %h", dmemrdata, ref_mem[255]); end
    tick();
    idle();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL io_unmapped_err: got %b want 0", bus_err); end
    bus(1'b1, 1'b0, 16'h0200, 16'h0);
    checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL hole_boundary: got %h want 0000", dmemrdata); end
    tick();
    idle();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL hole_boundary_err: got %b want 1", bus_err); end
    // odd address: access proceeds on the even word
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v = 16'($urandom);
    bus(1'b0, 1'b1, 16'h0021, v);
    tick();
    ref_mem[16] = v;
    bus(1'b1, 1'b0, 16'h0020, 16'h0);
    checks++; if (dmemrdata !== v) begin errors++; $display("FAIL odd_write: got %h want %h", dmemrdata, v); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL odd_err: got %b want 1", bus_err); end
    bus(1'b0, 1'b1, 16'hFF01, v);
    tick();
    idle();
    checks++; if (leds !== v[7:0]) begin errors++; $display("FAIL odd_led: got %h want %h", leds, v[7:0]); end
    $display("test_odd_hole done");
  endtask

  task automatic test_uart();
    logic [7:0] b;
    logic [9:0] frame;
    for (int n = 0; n < 3; n++) begin
      b = (n == 0) ? 8'h55 : 8'($urandom);
      frame = {1'b1, b, 1'b0};
      bus(1'b0, 1'b1, 16'hFF04, {8'($urandom), b});
      tick();
      for (int t = 0; t < 10 * CPB; t++) begin
        bus(1'b1, 1'b0, 16'hFF06, 16'h0);
        checks++; if (uart_tx !== frame[t / CPB]) begin errors++; $display("FAIL uart_bit byte=%h t=%0d: got %b want %b", b, t, uart_tx, frame[t / CPB]); end
        checks++; if (dmemrdata !== 16'h0001) begin errors++; $display("FAIL uart_busy t=%0d: got %h want 0001", t, dmemrdata); end
        tick();
      end
      bus(1'b1, 1'b0, 16'hFF06, 16'h0);
      checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL uart_idle_sta: got %h want 0000", dmemrdata); end
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL uart_idle_tx: got %b want 1", uart_tx); end
      bus(1'b1, 1'b0, 16'hFF04, 16'h0);
      checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL uartdat_read: got %h want 0000", dmemrdata); end
      idle();
      tick();
    end
    $display("test_uart done");
  endtask

  task automatic test_overrun();
    logic [7:0] a;
    logic [9:0] frame;
    a = 8'($urandom);
    frame = {1'b1, a, 1'b0};
    bus(1'b0, 1'b1, 16'hFF04, {8'h00, a});
    tick();
    for (int t = 0; t < 10 * CPB; t++) begin
      case (t)
        5: bus(1'b0, 1'b1, 16'hFF04, {8'h00, ~a});
        6: begin
          bus(1'b1, 1'b0, 16'hFF06, 16'h0);
          checks++; if (dmemrdata !== 16'h0003) begin errors++; $display("FAIL overrun_set: got %h want 0003", dmemrdata); end
        end
        7: bus(1'b0, 1'b1, 16'hFF06, 16'h0);
        8: begin
          bus(1'b1, 1'b0, 16'hFF06, 16'h0);
          checks++; if (dmemrdata !== 16'h0001) begin errors++; $display("FAIL overrun_clear: got %h want 0001", dmemrdata); end
        end
        default: idle();
      endcase
      checks++; if (uart_tx !== frame[t / CPB]) begin errors++; $display("FAIL overrun_frame t=%0d: got %b want %b", t, uart_tx, frame[t / CPB]); end
      tick();
    end
    bus(1'b1, 1'b0, 16'hFF06, 16'h0);
    checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL overrun_end_sta: got %h want 0000", dmemrdata); end
    // write landing in the last STOP cycle is still an overrun
    bus(1'b0, 1'b1, 16'hFF04, {8'h00, a});
    tick();
    for (int t = 0; t < 10 * CPB - 1; t++) begin
      idle();
      tick();
    end
    bus(1'b0, 1'b1, 16'hFF04, {8'h00, ~a});
    tick();
    bus(1'b1, 1'b0, 16'hFF06, 16'h0);
    checks++; if (dmemrdata !== 16'h0002) begin errors++; $display("FAIL overrun_stop_cycle: got %h want 0002", dmemrdata); end
    idle();
    for (int t = 0; t < 2 * CPB; t++) begin
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL dropped_no_frame t=%0d: got %b want 1", t, uart_tx); end
      tick();
    end
    bus(1'b0, 1'b1, 16'hFF06, 16'h0);
    tick();
    bus(1'b1, 1'b0, 16'hFF06, 16'h0);
    checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL overrun_final_clear: got %h want 0000", dmemrdata); end
    idle();
    $display("test_overrun done");
  endtask

  task automatic test_cycle();
    logic [15:0] v;
    int n;
    bus(1'b0, 1'b1, 16'hFF08, 16'hFFFE);
    tick();
    for (int k = 0; k < 3; k++) begin
      bus(1'b1, 1'b0, 16'hFF08, 16'h0);
      checks++; if (dmemrdata !== 16'(16'hFFFE + k)) begin errors++; $display("FAIL cycle_wrap k=%0d: got %h want %h", k, dmemrdata, 16'(16'hFFFE + k)); end
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      v = 16'($urandom);
      n = $urandom_range(0, 20);
      bus(1'b0, 1'b1, 16'hFF08, v);
      tick();
      idle();
      repeat (n) tick();
      bus(1'b1, 1'b0, 16'hFF08, 16'h0);
      checks++; if (dmemrdata !== 16'(v + n)) begin errors++; $display("FAIL cycle_rand v=%h n=%0d: got %h want %h", v, n, dmemrdata, 16'(v + n)); end
      idle();
    end
    $display("test_cycle done");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] lv;
    lv = 8'($urandom) | 8'h01;
    bus(1'b0, 1'b1, 16'hFF00, {8'h00, lv});
    tick();
    bus(1'b0, 1'b1, 16'hFF04, 16'h0000);
    tick();
    for (int t = 0; t < CPB + 2; t++) begin
      idle();
      tick();
    end
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_data0: got %b want 0", uart_tx); end
    bus(1'b0, 1'b1, 16'hFF04, 16'h00FF);
    tick();
    bus(1'b1, 1'b0, 16'hFF06, 16'h0);
    checks++; if (dmemrdata !== 16'h0003) begin errors++; $display("FAIL midframe_sta: got %h want 0003", dmemrdata); end
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_tx: got %b want 1", uart_tx); end
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL midframe_leds: got %h want 00", leds); end
    bus(1'b1, 1'b0, 16'hFF06, 16'h0);
    checks++; if (dmemrdata !== 16'h0000) begin errors++; $display("FAIL midframe_sta_reset: got %h want 0000", dmemrdata); end
    bus(1'b1, 1'b0, 16'h0010, 16'h0);
    checks++; if (dmemrdata !== ref_mem[8]) begin errors++; $display("FAIL midframe_ram: got %h want %h", dmemrdata, ref_mem[8]); end
    idle();
    for (int t = 0; t < 10 * CPB; t++) begin
      tick();
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL aborted_frame t=%0d: got %b want 1", t, uart_tx); end
    end
    $display("test_reset_midframe done");
  endtask

  initial begin
    test_reset();
    test_ram();
    test_leds_switches();
    test_odd_hole();
    test_uart();
    test_overrun();
    test_cycle();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
